seq_datapath: RTL and testbench
===============================

Name: seq_datapath

Overview:
- Parametrised successor to the bus-based register datapath.
- Keeps the same shared-bus, Y/Z register and HI/LO organisation, and generalises data width, register count and the R0 behaviour.
- Adds an internal micro-step sequencer, so one start pulse executes a complete three-operand ALU instruction (Ra <= Rb op Rc; MUL writes HI/LO) with a start/busy/done handshake.
- Sits between the future control unit and memory interface; the control unit issues decoded operations, a host/loader fills registers through a direct write port.

Parameters:
- DATA_W, 32: width of registers, bus, Y, HI, LO; Z is 2*DATA_W.
- NUM_REGS, 16: general-purpose register count (power of 2, 2..32).
- ADDR_W, 4: register address width, must equal clog2(NUM_REGS).
- R0_ZERO, 0: if 1, R0 reads as 0 and writes to R0 are discarded.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous active-low reset.
- start  in  1  request to execute an operation; sampled only in IDLE.
- op  in  4  operation code, latched on accept.
- ra  in  ADDR_W  destination register, latched on accept.
- rb  in  ADDR_W  source A (to Y), latched on accept.
- rc  in  ADDR_W  source B (direct bus to ALU), latched on accept.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse: illegal op, or ext write rejected while busy.
- ext_we  in  1  direct register write strobe.
- ext_waddr  in  ADDR_W  direct write address.
- ext_wdata  in  DATA_W  direct write data.
- rd_addr  in  ADDR_W  asynchronous read address.
- rd_data  out  DATA_W  combinational read of register rd_addr (0 for R0 when R0_ZERO=1).
- hi  out  DATA_W  HI register.
- lo  out  DATA_W  LO register.
- bus_out  out  DATA_W  current bus value, for observability.

Behaviour:
- Reset, when clr=0 at a clock edge:
  - All registers, HI, LO, Y, Z reset to 0 and the FSM goes to IDLE.
  - busy, done and err reset to 0.
  - start and ext_we are ignored that cycle; reset mid-sequence aborts it with no writeback.
- Op encoding: 0 ADD, 1 SUB (Y-bus), 2 AND, 3 OR, 4 SHL, 5 SHR (logical; shift amount = bus[clog2(DATA_W)-1:0]), 6 MUL (unsigned, 2*DATA_W product), 7 NOT (~bus), 8 NEG (0-bus).
- Ops 9-15 are illegal.
- Arithmetic wraps modulo 2^DATA_W. Non-MUL ops zero-extend their result into Z high.
- FSM states: IDLE, T_Y, T_Z, T_WB, T_WBH.
  - IDLE: start=1 latches op, ra, rb and rc. A legal op goes to T_Y. An illegal op stays in IDLE and pulses done and err together in the next cycle; nothing is written.
  - T_Y: bus = R[rb]; Y <= bus at the edge.
  - T_Z: bus = R[rc]; Z <= ALU(Y, bus) at the edge.
  - T_WB: bus = Z low. Non-MUL ops write R[ra] <= bus and go to IDLE. MUL writes LO <= bus and goes to T_WBH.
  - T_WBH: bus = Z high; HI <= bus; go to IDLE.
  - In IDLE, bus = R[rd_addr].
- Latency: start accepted at edge E0. Non-MUL writeback occurs at E3 and MUL writeback at E4. done is high for exactly the cycle following the final write edge.
- busy is high from after E0 until the final edge. The done cycle is IDLE, so a back-to-back start there is accepted.
- start while busy is ignored, with no err.
- ext_we:
  - In IDLE, the write happens at the clock edge.
  - While busy, the write is dropped and err pulses the next cycle.
  - If ext_we and start arrive in the same IDLE cycle, both take effect, and the sequence reads the newly written value.
- Reads of R0 return 0 when R0_ZERO=1; writes to R0 are discarded.
- ra == rb == rc is legal; sources are read before writeback.

Decomposition:
- Package seq_dp_pkg holds:
  - op encodings (OP_ADD..OP_NEG, OP_LAST);
  - the state enum (IDLE, T_Y, T_Z, T_WB, T_WBH);
  - helper function is_legal_op.
- Sub-module seq_dp_alu, parametrised on DATA_W: purely combinational; inputs y, b, op; output 2*DATA_W result.
- The register file, bus mux and FSM stay in seq_datapath.

Test Plan:
- Reset and ADD:
  - Stimulus: hold clr=0 for 2 cycles, then ext-write R1=5 and R2=7, then start ADD ra=3 rb=1 rc=2.
  - Required: busy for 3 cycles; R3=12 after E3; done pulses once; rd_data(3)=12.
- SUB wrap:
  - Stimulus: R1=0, R2=1, SUB into R4.
  - Required: R4=0xFFFFFFFF.
- MUL:
  - Stimulus: R5=0xFFFFFFFF, R6=2, MUL.
  - Required: LO=0xFFFFFFFE, HI=1; busy for 4 cycles; done one cycle after E4; no GP register changes.
- Ext write while busy:
  - Stimulus: ext_we to R7=9 during T_Z.
  - Required: err pulse; R7 unchanged.
- Illegal op and back-to-back start:
  - Stimulus: op=12.
  - Required: done and err pulse together; no writes.
  - Stimulus: start asserted in the done cycle of an ADD.
  - Required: second op accepted without bubble.
- R0_ZERO=1 and reset abort:
  - Stimulus: ext-write R0=3.
  - Required: rd_data(0)=0.
  - Stimulus: ADD with ra=0.
  - Required: R0 stays 0.
  - Stimulus: clr=0 asserted in T_Z.
  - Required: next cycle busy=0, Y=Z=0, destination unchanged.

Source files
------------

// File: rtl/seq_dp_pkg.sv
// Shared definitions for the sequenced register datapath: opcodes,
// sequencer states and opcode legality.
package seq_dp_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_NEG  = 4'd8;
  localparam logic [3:0] OP_LAST = OP_NEG;

  typedef enum logic [2:0] {
    IDLE,
    T_Y,
    T_Z,
    T_WB,
    T_WBH
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/seq_dp_alu.sv
// Combinational ALU: Y operand against the bus operand, 2*DATA_W result.
// Only MUL uses the upper half; every other op zero-extends.
module seq_dp_alu
  import seq_dp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   y,
  input  logic [DATA_W-1:0]   b,
  input  logic [3:0]          op,
  output logic [2*DATA_W-1:0] result
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0] narrow;
  logic [SH_W-1:0]   shamt;

  assign shamt = b[SH_W-1:0];

  always_comb begin
    narrow = '0;
    result = '0;
    case (op)
      OP_ADD:  narrow = y + b;
      OP_SUB:  narrow = y - b;
      OP_AND:  narrow = y & b;
      OP_OR:   narrow = y | b;
      OP_SHL:  narrow = y << shamt;
      OP_SHR:  narrow = y >> shamt;
      OP_NOT:  narrow = ~b;
      OP_NEG:  narrow = '0 - b;
      default: narrow = '0;
    endcase
    if (op == OP_MUL)
      result = {{DATA_W{1'b0}}, y} * {{DATA_W{1'b0}}, b};
    else
      result = {{DATA_W{1'b0}}, narrow};
  end

endmodule

// File: rtl/seq_datapath.sv
// Shared-bus register datapath with a micro-step sequencer: one start
// pulse runs Ra <= Rb op Rc (MUL writes LO then HI) via Y and Z.
module seq_datapath
  import seq_dp_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int R0_ZERO  = 0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] rc,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_waddr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] bus_out
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  state_t              state;
  logic [3:0]          op_q;
  logic [ADDR_W-1:0]   ra_q;
  logic [ADDR_W-1:0]   rb_q;
  logic [ADDR_W-1:0]   rc_q;
  logic [DATA_W-1:0]   y;
  logic [2*DATA_W-1:0] z;
  logic [2*DATA_W-1:0] alu_res;
  logic [DATA_W-1:0]   bus;
  logic                ext_wr_ok;
  logic                wb_wr_ok;

  function automatic logic is_r0_locked(input logic [ADDR_W-1:0] a);
    return (R0_ZERO != 0) && (a == '0);
  endfunction

  function automatic logic [DATA_W-1:0] read_reg(input logic [ADDR_W-1:0] a);
    if (is_r0_locked(a))
      return '0;
    return regs[a];
  endfunction

  assign ext_wr_ok = ext_we && (state == IDLE) && !is_r0_locked(ext_waddr);
  assign wb_wr_ok  = (state == T_WB) && (op_q != OP_MUL) && !is_r0_locked(ra_q);

  assign rd_data = read_reg(rd_addr);
  assign bus_out = bus;

  // The bus source is fixed by the micro-step; IDLE exposes the read port.
  always_comb begin
    bus = '0;
    case (state)
      IDLE:    bus = read_reg(rd_addr);
      T_Y:     bus = read_reg(rb_q);
      T_Z:     bus = read_reg(rc_q);
      T_WB:    bus = z[DATA_W-1:0];
      T_WBH:   bus = z[2*DATA_W-1:DATA_W];
      default: bus = '0;
    endcase
  end

  seq_dp_alu #(.DATA_W(DATA_W)) u_alu (
    .y      (y),
    .b      (bus),
    .op     (op_q),
    .result (alu_res)
  );

  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      if (ext_wr_ok)
        regs[ext_waddr] <= ext_wdata;
      if (wb_wr_ok)
        regs[ra_q] <= bus;
    end
  end

  // Sequencer: busy/done/err are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
      y     <= '0;
      z     <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            ra_q <= ra;
            rb_q <= rb;
            rc_q <= rc;
            if (is_legal_op(op)) begin
              state <= T_Y;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
              err  <= 1'b1;
            end
          end
        end
        T_Y: begin
          y     <= bus;
          state <= T_Z;
        end
        T_Z: begin
          z     <= alu_res;
          state <= T_WB;
        end
        T_WB: begin
          if (op_q == OP_MUL) begin
            lo    <= bus;
            state <= T_WBH;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        T_WBH: begin
          hi    <= bus;
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (ext_we && (state != IDLE))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_datapath.sv
// Scoreboard bench for seq_datapath (R0_ZERO=1): directed cases plus random
// instruction streams checked against an arithmetic reference model.
module tb_seq_datapath;

  localparam int DW  = 32;
  localparam int NR  = 16;
  localparam int AW  = 4;
  localparam int R0Z = 1;

  typedef struct packed {
    logic                  illegal;
    logic [NR-1:0][DW-1:0] regs;
    logic [DW-1:0]         hi;
    logic [DW-1:0]         lo;
  } done_rec_t;

  logic          clk = 1'b0;
  logic          clr;
  logic          start;
  logic [3:0]    op;
  logic [AW-1:0] ra, rb, rc;
  logic          busy, done, err;
  logic          ext_we;
  logic [AW-1:0] ext_waddr;
  logic [DW-1:0] ext_wdata;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, hi, lo, bus_out;

  int compared = 0;
  int mismatched = 0;

  done_rec_t done_q[$];
  int        ext_q[$];

  logic [DW-1:0] m_regs [NR];
  logic [DW-1:0] m_hi, m_lo;

  always #5 clk = ~clk;

  seq_datapath #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .R0_ZERO(R0Z)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .op        (op),
    .ra        (ra),
    .rb        (rb),
    .rc        (rc),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .ext_we    (ext_we),
    .ext_waddr (ext_waddr),
    .ext_wdata (ext_wdata),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .hi        (hi),
    .lo        (lo),
    .bus_out   (bus_out)
  );

  // Reference ALU written as modular arithmetic over unbounded integers.
  function automatic logic [63:0] ref_alu(input logic [3:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint unsigned m  = 64'h1_0000_0000;
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint unsigned p  = 64'd1 << (ub % 32);
    case (o)
      4'd0:    return (ua + ub) % m;
      4'd1:    return (ua + m - ub) % m;
      4'd2:    return 64'(a & b);
      4'd3:    return 64'(a | b);
      4'd4:    return (ua * p) % m;
      4'd5:    return ua / p;
      4'd6:    return ua * ub;
      4'd7:    return (m - 1) - ub;
      4'd8:    return (m - ub) % m;
      default: return 64'd0;
    endcase
  endfunction

  function automatic done_rec_t snapshot(input logic illegal);
    done_rec_t r;
    r.illegal = illegal;
    for (int i = 0; i < NR; i++)
      r.regs[i] = m_regs[i];
    r.hi = m_hi;
    r.lo = m_lo;
    return r;
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!(R0Z != 0 && a == 0))
      m_regs[a] = d;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NR; i++)
      m_regs[i] = '0;
    m_hi = '0;
    m_lo = '0;
  endfunction

  function automatic logic [DW-1:0] rand_val();
    case ($urandom % 4)
      0:       return '0;
      1:       return '1;
      2:       return DW'($urandom_range(0, 40));
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ext_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ext_we    = 1'b1;
    ext_waddr = a;
    ext_wdata = d;
    model_write(a, d);
    @(posedge clk);
    #1;
    ext_we = 1'b0;
  endtask

  task automatic check_rd(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd_addr = a;
    #1;
    checkOutput(name, 64'(rd_data), 64'(exp));
  endtask

  // Issues one instruction from IDLE and returns in its done cycle.
  // reject_at >= 0 fires an ext write that many cycles after accept.
  task automatic applyStimulus(input logic [3:0] o, input logic [AW-1:0] a, input logic [AW-1:0] b,
                               input logic [AW-1:0] c, input bit same_ext, input logic [AW-1:0] se_addr,
                               input logic [DW-1:0] se_data, input int reject_at,
                               input logic [AW-1:0] rj_addr, input logic [DW-1:0] rj_data);
    bit          legal = (o <= 4'd8);
    int          n     = legal ? ((o == 4'd6) ? 4 : 3) : 0;
    logic [63:0] res;
    start = 1'b1;
    op    = o;
    ra    = a;
    rb    = b;
    rc    = c;
    if (same_ext) begin
      ext_we    = 1'b1;
      ext_waddr = se_addr;
      ext_wdata = se_data;
      model_write(se_addr, se_data);
    end
    if (legal) begin
      res = ref_alu(o, m_regs[b], m_regs[c]);
      if (o == 4'd6) begin
        m_lo = res[DW-1:0];
        m_hi = res[2*DW-1:DW];
      end else begin
        model_write(a, res[DW-1:0]);
      end
    end
    done_q.push_back(snapshot(!legal));
    @(posedge clk);
    #1;
    start  = 1'b0;
    ext_we = 1'b0;
    for (int k = 0; k < n; k++) begin
      checkOutput("busy_run", 64'(busy), 64'd1);
      if (k == reject_at) begin
        ext_we    = 1'b1;
        ext_waddr = rj_addr;
        ext_wdata = rj_data;
        ext_q.push_back(1);
      end
      @(posedge clk);
      #1;
      ext_we = 1'b0;
    end
    checkOutput("busy_end", 64'(busy), 64'd0);
  endtask

  task automatic run_op(input logic [3:0] o, input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c);
    applyStimulus(o, a, b, c, 1'b0, '0, '0, -1, '0, '0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals completion or error.
  always @(negedge clk) begin
    if (clr === 1'b1) begin
      if (done === 1'b1) begin
        compared++;
        if (done_q.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL done_pulse: got unexpected done expected none");
        end else begin
          done_rec_t r;
          int bad;
          r   = done_q.pop_front();
          bad = 0;
          for (int i = 0; i < NR; i++)
            if (dut.regs[i] !== r.regs[i])
              bad++;
          if (err !== r.illegal || hi !== r.hi || lo !== r.lo || bad != 0) begin
            mismatched++;
            $display("[TB] FAIL done_check: got err=%b hi=%h lo=%h badregs=%0d expected err=%b hi=%h lo=%h badregs=0",
                     err, hi, lo, bad, r.illegal, r.hi, r.lo);
          end
        end
      end else if (err === 1'b1) begin
        compared++;
        if (ext_q.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL err_pulse: got unexpected err expected none");
        end else begin
          void'(ext_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clr       = 1'b0;
    start     = 1'b0;
    op        = '0;
    ra        = '0;
    rb        = '0;
    rc        = '0;
    ext_we    = 1'b0;
    ext_waddr = '0;
    ext_wdata = '0;
    rd_addr   = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_err", 64'(err), 64'd0);
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    check_rd("reset_r3", 4'd3, 32'd0);
    clr = 1'b1;

    ext_write(4'd1, 32'd5);
    ext_write(4'd2, 32'd7);
    run_op(4'd0, 4'd3, 4'd1, 4'd2);
    check_rd("add_r3", 4'd3, 32'd12);
    checkOutput("idle_bus", 64'(bus_out), 64'd12);

    ext_write(4'd1, 32'd0);
    ext_write(4'd2, 32'd1);
    run_op(4'd1, 4'd4, 4'd1, 4'd2);
    check_rd("sub_wrap", 4'd4, 32'hFFFF_FFFF);

    ext_write(4'd5, 32'hFFFF_FFFF);
    ext_write(4'd6, 32'd2);
    run_op(4'd6, 4'd8, 4'd5, 4'd6);
    checkOutput("mul_lo", 64'(lo), 64'hFFFF_FFFE);
    checkOutput("mul_hi", 64'(hi), 64'd1);

    ext_write(4'd7, 32'h55);
    applyStimulus(4'd0, 4'd9, 4'd5, 4'd6, 1'b0, '0, '0, 1, 4'd7, 32'd9);
    check_rd("reject_r7", 4'd7, 32'h55);

    run_op(4'd12, 4'd3, 4'd1, 4'd2);
    check_rd("illegal_r3", 4'd3, 32'd12);

    run_op(4'd0, 4'd10, 4'd3, 4'd4);
    run_op(4'd1, 4'd11, 4'd10, 4'd3);
    check_rd("b2b_r11", 4'd11, 32'd0 - 32'd1 - 32'd12 + 32'd12 - 32'd12 + 32'd12);

    applyStimulus(4'd0, 4'd12, 4'd1, 4'd1, 1'b1, 4'd1, 32'd100, -1, '0, '0);
    check_rd("same_cycle_ext", 4'd12, 32'd200);

    ext_write(4'd0, 32'd3);
    check_rd("r0_ext", 4'd0, 32'd0);
    run_op(4'd0, 4'd0, 4'd1, 4'd2);
    check_rd("r0_add", 4'd0, 32'd0);

    for (int t = 0; t < 200; t++) begin
      logic [3:0] o;
      int         rej;
      o   = ($urandom % 10 == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      rej = (o <= 4'd8 && $urandom % 3 == 0) ? int'($urandom_range(0, 1)) : -1;
      applyStimulus(o, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), rand_val(),
                    rej, 4'($urandom), rand_val());
      if ($urandom % 2 == 0)
        ext_write(4'($urandom), rand_val());
      if ($urandom % 3 == 0)
        idle_cycle();
    end

    ext_write(4'd1, 32'd20);
    ext_write(4'd2, 32'd22);
    start = 1'b1;
    op    = 4'd0;
    ra    = 4'd13;
    rb    = 4'd1;
    rc    = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_y", 64'(dut.y), 64'd0);
    checkOutput("abort_z", dut.z, 64'd0);
    clr = 1'b1;
    idle_cycle();
    check_rd("abort_dest", 4'd13, 32'd0);
    checkOutput("abort_done", 64'(done), 64'd0);

    repeat (3) idle_cycle();
    checkOutput("done_q_empty", 64'(done_q.size()), 64'd0);
    checkOutput("ext_q_empty", 64'(ext_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
